// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one backing-memory port between the icache refill
// path and the dcache refill/writeback path. One transaction in flight at a time.
// Each response is routed to the requester that owns it.
// Build option: define MEM_ARB_RR_EN for round-robin tie-breaking. Otherwise the
// arbiter gives dcache fixed priority and a starvation counter protects icache.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 128,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_resp_valid,
  output logic [DATA_W-1:0] ic_resp_data,
  input  logic              dc_req_valid,
  input  logic              dc_req_rw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [DATA_W-1:0] dc_req_data,
  output logic              dc_req_ready,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] dc_resp_data,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              mem_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state;
  logic              owner_ic;   // 1: in-flight transaction belongs to icache
  logic [DATA_W-1:0] resp_data;  // last response line, shared by both return ports
  logic              grant_ic;
  logic              grant_dc;

`ifdef MEM_ARB_RR_EN
  logic last_grant;  // 0 = dcache was granted last, 1 = icache

  // Round-robin winner selection: on a tie the requester not served last wins.
  always_comb begin
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    if (state == IDLE) begin
      if (ic_req_valid && dc_req_valid) begin
        if (last_grant) grant_dc = 1'b1;
        else            grant_ic = 1'b1;
      end else begin
        grant_ic = ic_req_valid;
        grant_dc = dc_req_valid;
      end
    end
  end

  // Remember which requester was served most recently.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b0;
    end else if (grant_ic) begin
      last_grant <= 1'b1;
    end else if (grant_dc) begin
      last_grant <= 1'b0;
    end
  end
`else
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

  // Fixed priority winner selection: dcache wins ties unless icache is starved.
  always_comb begin
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    if (state == IDLE) begin
      if (ic_req_valid && dc_req_valid) begin
        if (starved) grant_ic = 1'b1;
        else         grant_dc = 1'b1;
      end else begin
        grant_ic = ic_req_valid;
        grant_dc = dc_req_valid;
      end
    end
  end

  // Count dcache grants that passed over a waiting icache; saturate at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_dc) begin
      if (!ic_req_valid) starve_cnt <= '0;
      else if (!starved) starve_cnt <= starve_cnt + CNT_W'(1);
    end else if (grant_ic) begin
      starve_cnt <= '0;
    end
  end
`endif

  assign ic_req_ready = grant_ic;
  assign dc_req_ready = grant_dc;
  assign ic_resp_data = resp_data;
  assign dc_resp_data = resp_data;

  // Transaction FSM: latch the winner, present it to memory, then return the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      owner_ic      <= 1'b0;
      resp_data     <= '0;
      ic_resp_valid <= 1'b0;
      dc_resp_valid <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_rw    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      mem_busy      <= 1'b0;
    end else begin
      ic_resp_valid <= 1'b0;
      dc_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ic || grant_dc) begin
            owner_ic      <= grant_ic;
            mem_req_valid <= 1'b1;
            mem_req_rw    <= grant_dc ? dc_req_rw : 1'b0;
            mem_req_addr  <= grant_dc ? dc_req_addr : ic_req_addr;
            mem_req_data  <= grant_dc ? dc_req_data : '0;
            mem_busy      <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          // Request fields are held until memory takes them; stray responses ignored.
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            resp_data     <= mem_resp_data;
            ic_resp_valid <= owner_ic;
            dc_resp_valid <= !owner_ic;
            mem_busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter. A cycle-by-cycle
// vector table covers the basic flows; hand-written sequences cover starvation /
// round-robin, a stalled dcache write, and reset while waiting for memory.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic              ic_req_valid;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_req_ready;
  logic              ic_resp_valid;
  logic [DATA_W-1:0] ic_resp_data;
  logic              dc_req_valid;
  logic              dc_req_rw;
  logic [ADDR_W-1:0] dc_req_addr;
  logic [DATA_W-1:0] dc_req_data;
  logic              dc_req_ready;
  logic              dc_resp_valid;
  logic [DATA_W-1:0] dc_resp_data;
  logic              mem_req_valid;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic              mem_busy;

  int checks = 0;
  int errors = 0;

  localparam logic [ADDR_W-1:0] IC_ADDR = 32'h0000_1000;
  localparam logic [ADDR_W-1:0] DC_ADDR = 32'h0000_2000;
  localparam logic [DATA_W-1:0] RD_LINE = {16{8'hA5}};
  localparam logic [DATA_W-1:0] WB_LINE = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data), .dc_req_ready(dc_req_ready),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus and the outputs expected in that same cycle.
  typedef struct {
    logic              ic_v, dc_v, dc_rw, m_rdy, m_rv;
    logic [6:0]        exp;      // {ic_rdy, dc_rdy, mem_v, mem_rw, busy, ic_rv, dc_rv}
    logic [ADDR_W-1:0] exp_addr; // checked when mem_v expected
    logic              chk_data; // check returned line equals RD_LINE
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic [4:0] in, input logic [6:0] exp,
                              input logic [ADDR_W-1:0] a, input logic cd);
    vec_t v;
    {v.ic_v, v.dc_v, v.dc_rw, v.m_rdy, v.m_rv} = in;
    v.exp = exp;
    v.exp_addr = a;
    v.chk_data = cd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Wait for a grant, run the memory handshake, and check the response routing.
  task automatic serve(output int who);
    who = -1;
    for (int i = 0; i < 20; i++) begin
      if (dc_req_ready) begin who = 1; break; end
      if (ic_req_ready) begin who = 0; break; end
      @(negedge clk); #1;
    end
    if (who < 0) begin
      chk("grant_timeout", 1'b0, 1'b1);
      return;
    end
    @(negedge clk); mem_req_ready = 1'b1; #1;
    chk("serve_issue_addr", {mem_req_valid, mem_req_addr}, {1'b1, (who == 1) ? DC_ADDR : IC_ADDR});
    @(negedge clk); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; #1;
    @(negedge clk); mem_resp_valid = 1'b0; #1;
    chk("serve_resp_route", {ic_resp_valid, dc_resp_valid}, {who == 0, who == 1});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int who;
    int exp_who[6];
    reset = 1'b1;
    ic_req_valid = 1'b0; ic_req_addr = IC_ADDR;
    dc_req_valid = 1'b0; dc_req_rw = 1'b0; dc_req_addr = DC_ADDR; dc_req_data = WB_LINE;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = RD_LINE;

    //                in {ic,dc,rw,rdy,rv}  exp {icr,dcr,mv,rw,busy,icv,dcv}
    vecs[0]  = mk(5'b00000, 7'b0000000, '0, 0);
    vecs[1]  = mk(5'b10000, 7'b1000000, '0, 0);       // ic read accepted (T)
    vecs[2]  = mk(5'b00010, 7'b0010100, IC_ADDR, 0);  // T+1 issue, memory accepts
    vecs[3]  = mk(5'b00000, 7'b0000100, '0, 0);       // T+2 wait
    vecs[4]  = mk(5'b00001, 7'b0000100, '0, 0);       // T+3 memory responds
    vecs[5]  = mk(5'b00000, 7'b0000010, '0, 1);       // T+4 icache pulse
    vecs[6]  = mk(5'b00000, 7'b0000000, '0, 0);
    vecs[7]  = mk(5'b11000, 7'b0100000, '0, 0);       // tie: dcache wins
    vecs[8]  = mk(5'b10010, 7'b0010100, DC_ADDR, 0);  // ic held, no ready while busy
    vecs[9]  = mk(5'b10001, 7'b0000100, '0, 0);
    vecs[10] = mk(5'b10000, 7'b1000001, '0, 1);       // dc pulse + ic accepted back-to-back
    vecs[11] = mk(5'b00010, 7'b0010100, IC_ADDR, 0);
    vecs[12] = mk(5'b00001, 7'b0000100, '0, 0);
    vecs[13] = mk(5'b00000, 7'b0000010, '0, 1);
    vecs[14] = mk(5'b00001, 7'b0000000, '0, 0);       // stray response in IDLE
    vecs[15] = mk(5'b00000, 7'b0000000, '0, 0);
    vecs[16] = mk(5'b01100, 7'b0100000, '0, 0);       // dc write accepted
    vecs[17] = mk(5'b00001, 7'b0011100, DC_ADDR, 0);  // stray response in ISSUE
    vecs[18] = mk(5'b00010, 7'b0011100, DC_ADDR, 0);
    vecs[19] = mk(5'b00000, 7'b0000100, '0, 0);
    vecs[20] = mk(5'b00001, 7'b0000100, '0, 0);
    vecs[21] = mk(5'b00000, 7'b0000001, '0, 0);       // write ack
    vecs[22] = mk(5'b00000, 7'b0000000, '0, 0);

    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid, mem_req_valid, mem_busy}, 6'b0);
    chk("reset_mem_addr", mem_req_addr, '0);
    chk("reset_mem_data", mem_req_data, '0);
    chk("reset_resp_data", ic_resp_data, '0);
    @(negedge clk); reset = 1'b0;

    // Vector table
    for (int i = 0; i < 23; i++) begin
      logic [6:0] act;
      @(negedge clk);
      ic_req_valid = vecs[i].ic_v; dc_req_valid = vecs[i].dc_v; dc_req_rw = vecs[i].dc_rw;
      mem_req_ready = vecs[i].m_rdy; mem_resp_valid = vecs[i].m_rv;
      #1;
      act = {ic_req_ready, dc_req_ready, mem_req_valid, mem_req_rw & mem_req_valid,
             mem_busy, ic_resp_valid, dc_resp_valid};
      chk($sformatf("vec%0d_ctrl", i), act, vecs[i].exp);
      if (vecs[i].exp[4]) chk($sformatf("vec%0d_addr", i), mem_req_addr, vecs[i].exp_addr);
      if (vecs[i].chk_data)
        chk($sformatf("vec%0d_data", i), ic_resp_valid ? ic_resp_data : dc_resp_data, RD_LINE);
    end

    // Both requesters held valid: grant order
`ifdef MEM_ARB_RR_EN
    exp_who = '{0, 1, 0, 1, 0, 1};
`else
    exp_who = '{1, 1, 1, 1, 0, 1};
`endif
    @(negedge clk);
    ic_req_valid = 1'b1; dc_req_valid = 1'b1; dc_req_rw = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    #1;
    for (int g = 0; g < 6; g++) begin
      serve(who);
      chk($sformatf("grant%0d_owner", g), who, exp_who[g]);
    end
    ic_req_valid = 1'b0; dc_req_valid = 1'b0;

    // dcache write with memory stalling for 3 cycles
    @(negedge clk);
    dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_addr = 32'h0000_0100; dc_req_data = WB_LINE;
    #1;
    chk("wr_accept", {dc_req_ready, ic_req_ready}, 2'b10);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); dc_req_valid = 1'b0; mem_req_ready = 1'b0; #1;
      chk($sformatf("wr_hold%0d", k), {mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data},
          {1'b1, 1'b1, 32'h0000_0100, WB_LINE});
    end
    @(negedge clk); mem_req_ready = 1'b1; #1;
    chk("wr_issue_still", {mem_req_valid, mem_busy}, 2'b11);
    @(negedge clk); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; #1;
    chk("wr_wait", {mem_req_valid, mem_busy, dc_resp_valid}, 3'b010);
    @(negedge clk); mem_resp_valid = 1'b0; #1;
    chk("wr_ack_pulse", {dc_resp_valid, ic_resp_valid, mem_busy}, 3'b100);
    @(negedge clk); #1;
    chk("wr_ack_single", {dc_resp_valid, ic_resp_valid}, 2'b00);

    // Reset while waiting for memory abandons the transaction
    dc_req_addr = DC_ADDR; dc_req_rw = 1'b0; dc_req_valid = 1'b1;
    #1;
    chk("rst_accept", dc_req_ready, 1'b1);
    @(negedge clk); dc_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk); mem_req_ready = 1'b0; reset = 1'b1; #1;
    chk("rst_in_wait", {mem_busy, mem_req_valid}, 2'b10);
    @(negedge clk); reset = 1'b0; mem_resp_valid = 1'b1; #1;
    chk("rst_cleared", {mem_busy, mem_req_valid, ic_resp_valid, dc_resp_valid}, 4'b0);
    chk("rst_addr_zero", mem_req_addr, '0);
    @(negedge clk); mem_resp_valid = 1'b0; #1;
    chk("rst_no_resp", {ic_resp_valid, dc_resp_valid, mem_busy}, 3'b0);
    chk("rst_resp_data", dc_resp_data, '0);
    @(negedge clk); #1;
    chk("rst_idle", {ic_resp_valid, dc_resp_valid, mem_busy, mem_req_valid}, 4'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
